mp_add_sequencer: RTL and testbench
===================================

Name: mp_add_sequencer

Overview:
- Multi-precision add/subtract front-end that sits directly upstream of the team's 64-bit carry-lookahead adder.
- Accepts an operand stream of 64-bit word pairs, least-significant word first, over a valid/ready handshake.
- Feeds each pair to the adder with the correct carry-in, chains the carry-out across words, and registers results into a one-entry output stage with backpressure.
- Supports arbitrary-length add and subtract (two's complement).

Parameters:
- WORD_W, 64, operand/result word width; must equal the adder width.
- IDX_W, 8, width of the word-index counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  input beat valid.
- in_ready  output  1  sequencer can accept a beat.
- in_a  input  WORD_W  operand A word.
- in_b  input  WORD_W  operand B word.
- in_first  input  1  beat is the least-significant word of a new operation.
- in_last  input  1  beat is the most-significant word of the operation.
- in_sub  input  1  operation is A−B; sampled only on a first beat.
- out_valid  output  1  result word valid.
- out_ready  input  1  consumer accepts the result word.
- out_sum  output  WORD_W  result word.
- out_idx  output  IDX_W  word index within the operation, 0 for the first word.
- out_last  output  1  result word is the final word.
- out_carry  output  1  carry-out of the final word (subtract: 1 = no borrow); 0 when out_last=0.
- out_ovf  output  1  signed overflow of the final word; 0 when out_last=0.
- out_err  output  1  protocol error flagged on this beat.

Behaviour:
- Accept condition: in_valid && in_ready.
- in_ready = !out_valid || out_ready. Single-cycle pipeline with full throughput and no combinational path from in_valid to in_ready.
- Latency: a beat accepted in cycle N appears on out_* in cycle N+1.
- out_* hold stable while out_valid && !out_ready.
- Adder operands:
  - a = in_a.
  - b = sub ? ~in_b : in_b.
  - cin = first-beat ? in_sub : carry_q.
  - sub = in_sub on a first beat, otherwise the latched sub_q.
- States:
  - IDLE: waiting for a first beat.
  - BUSY: mid-operation.
  - Any accepted beat with in_last → IDLE.
  - Any accepted beat without in_last → BUSY.
- On every accepted beat:
  - carry_q ← adder cout.
  - sub_q ← sub.
  - idx_q ← first-beat ? 1 : idx_q+1, wrapping modulo 2^IDX_W.
  - out_idx = the index of the beat itself: 0 on a first beat, else the old idx_q.
- First-beat rule: a beat is treated as first if in_first=1 or the state is IDLE.
- Protocol errors (the beat is still processed; out_err=1 on its output word):
  - Beat in IDLE with in_first=0.
  - Beat in BUSY with in_first=1. The previous operation is abandoned with no final word emitted; a new operation starts.
- A single-word operation has in_first=in_last=1.
- Overflow: out_ovf = carry into the MSB XOR cout, i.e. (a[MSB]^b[MSB]^sum[MSB]) ^ cout, computed on post-inversion operands.
- Reset (rst_n=0 at a clock edge, including mid-operation or while stalled):
  - state=IDLE, carry_q=0, sub_q=0, idx_q=0.
  - out_valid=0 and out_sum, out_idx, out_last, out_carry, out_ovf, out_err all 0.
  - Any held result is discarded.
- With both sides active in the same cycle, the output register captures the new beat while the old one is consumed; no bubble.

Test Plan:
- Two-word add: beats {a=FFFF_FFFF_FFFF_FFFF, b=1, first} then {a=1, b=0, last} → out_sum 0 (idx 0), then 2 (idx 1, last), out_carry=0, out_ovf=0.
- Single-word subtract: a=5, b=7, in_sub=1, first+last → out_sum=FFFF_FFFF_FFFF_FFFE, out_carry=0, out_ovf=0. Same with a=7, b=5 → 2, out_carry=1.
- Signed overflow: a=7FFF_FFFF_FFFF_FFFF, b=1, add, single word → out_sum=8000_0000_0000_0000, out_ovf=1, out_carry=0.
- Backpressure: 4-word stream with out_ready held low for 3 cycles after the first result → in_ready=0 during the stall, out_sum/out_idx unchanged, all 4 words delivered in order with correct carries and no duplicates.
- Protocol error: first beat, then a second beat with in_first=1 → second output has out_err=1, out_idx=0, and cin taken from in_sub rather than carry_q. A beat without in_first in IDLE → out_err=1, out_idx=0.
- Reset mid-operation: assert rst_n=0 after word 1 of 3 while out_valid=1 → next cycle out_valid=0 and all outputs 0. A following single-word add of 3+4 → 7, out_idx 0, out_err=0.

Source files
------------

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer feeding a WORD_W-bit adder.
// Operands arrive least-significant word first over valid/ready. The carry is
// chained across words and each result is held in a one-entry output register.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    input beat handshake
//   in_a, in_b           operand words
//   in_first, in_last    operation framing
//   in_sub               subtract select (sampled on a first beat)
//   out_valid/out_ready  result handshake
//   out_sum, out_idx     result word and its index within the operation
//   out_last             final word of the operation
//   out_carry, out_ovf   final-word carry-out / signed overflow (0 otherwise)
//   out_err              protocol error on this beat
module mp_add_sequencer #(
    parameter int unsigned WORD_W = 64,
    parameter int unsigned IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic              in_first,
    input  logic              in_last,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              out_carry,
    output logic              out_ovf,
    output logic              out_err
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e state_q, state_d;

    logic              carry_q, carry_d;
    logic              sub_q, sub_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_sum_q, out_sum_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;
    logic              out_carry_q, out_carry_d;
    logic              out_ovf_q, out_ovf_d;
    logic              out_err_q, out_err_d;

    logic              accept_c;
    logic              first_c;
    logic              sub_c;
    logic              cin_c;
    logic              err_c;
    logic [WORD_W-1:0] b_eff_c;
    logic [WORD_W:0]   sum_c;
    logic              cout_c;
    logic              ovf_c;

    // Ready depends only on the output register, never on in_valid.
    assign in_ready = !out_valid_q || out_ready;
    assign accept_c = in_valid && in_ready;

    // A beat starts a new operation if flagged first or nothing is in flight.
    assign first_c = in_first || (state_q == IDLE);
    assign err_c   = (state_q == IDLE) ? !in_first : in_first;
    assign sub_c   = first_c ? in_sub : sub_q;
    assign cin_c   = first_c ? in_sub : carry_q;
    assign b_eff_c = sub_c ? ~in_b : in_b;

    // Adder plus overflow taken from the carry into the MSB.
    assign sum_c  = {1'b0, in_a} + {1'b0, b_eff_c} + (WORD_W+1)'(cin_c);
    assign cout_c = sum_c[WORD_W];
    assign ovf_c  = (in_a[WORD_W-1] ^ b_eff_c[WORD_W-1] ^ sum_c[WORD_W-1]) ^ cout_c;

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_carry_q <= out_carry_d;
            out_ovf_q   <= out_ovf_d;
            out_err_q   <= out_err_d;
        end
    end

    // Next-state: every accepted beat decides IDLE vs BUSY by in_last.
    always_comb begin
        state_d = state_q;
        if (accept_c) begin
            state_d = in_last ? IDLE : BUSY;
        end
    end

    // Chain state and output register next values.
    always_comb begin
        carry_d     = carry_q;
        sub_d       = sub_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_carry_d = out_carry_q;
        out_ovf_d   = out_ovf_q;
        out_err_d   = out_err_q;
        if (accept_c) begin
            carry_d     = cout_c;
            sub_d       = sub_c;
            idx_d       = first_c ? IDX_W'(1) : idx_q + IDX_W'(1);
            out_valid_d = 1'b1;
            out_sum_d   = sum_c[WORD_W-1:0];
            out_idx_d   = first_c ? '0 : idx_q;
            out_last_d  = in_last;
            out_carry_d = in_last && cout_c;
            out_ovf_d   = in_last && ovf_c;
            out_err_d   = err_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_carry = out_carry_q;
    assign out_ovf   = out_ovf_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Scoreboard bench for mp_add_sequencer: directed beats push hand-computed
// results; a monitor pops and compares every consumed output word.
module tb_mp_add_sequencer;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned IDX_W  = 8;

    typedef struct {
        logic [WORD_W-1:0] sum;
        logic [IDX_W-1:0]  idx;
        logic              last;
        logic              carry;
        logic              ovf;
        logic              err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_a;
    logic [WORD_W-1:0] in_b;
    logic              in_first;
    logic              in_last;
    logic              in_sub;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_sum;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              out_carry;
    logic              out_ovf;
    logic              out_err;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    mp_add_sequencer #(.WORD_W(WORD_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .in_first(in_first), .in_last(in_last), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_idx(out_idx), .out_last(out_last),
        .out_carry(out_carry), .out_ovf(out_ovf), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] s, input int i, input logic l,
                                input logic c, input logic o, input logic e);
        exp_t x;
        x.sum = s; x.idx = IDX_W'(i); x.last = l; x.carry = c; x.ovf = o; x.err = e;
        return x;
    endfunction

    // Present one beat, wait (bounded) for acceptance, record its expectation.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic f,
                        input logic l, input logic s, input exp_t e);
        int n;
        @(negedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b; in_first = f; in_last = l; in_sub = s;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: compare consumed words, and check stall behaviour.
    logic [WORD_W-1:0] held_sum;
    logic [IDX_W-1:0]  held_idx;
    logic              was_stalled = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                was_stalled = 1'b0;
            end else begin
                if (was_stalled && out_valid) begin
                    chk("stall_sum_stable", out_sum, held_sum);
                    chk("stall_idx_stable", 64'(out_idx), 64'(held_idx));
                end
                if (out_valid && !out_ready) begin
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                    held_sum    = out_sum;
                    held_idx    = out_idx;
                    was_stalled = 1'b1;
                end else begin
                    was_stalled = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_output: got sum %h idx %0d with empty scoreboard",
                                 out_sum, out_idx);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sum",   out_sum, e.sum);
                        chk("idx",   64'(out_idx), 64'(e.idx));
                        chk("last",  64'(out_last), 64'(e.last));
                        chk("carry", 64'(out_carry), 64'(e.carry));
                        chk("ovf",   64'(out_ovf), 64'(e.ovf));
                        chk("err",   64'(out_err), 64'(e.err));
                    end
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d words never delivered", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_sum"},   out_sum, 64'd0);
        chk({tag, "_out_idx"},   64'(out_idx), 64'd0);
        chk({tag, "_out_last"},  64'(out_last), 64'd0);
        chk({tag, "_out_carry"}, 64'(out_carry), 64'd0);
        chk({tag, "_out_ovf"},   64'(out_ovf), 64'd0);
        chk({tag, "_out_err"},   64'(out_err), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Two-word add with carry across words.
        send(ALL1, 64'd1, 1, 0, 0, mk(64'd0, 0, 0, 0, 0, 0));
        send(64'd1, 64'd0, 0, 1, 0, mk(64'd2, 1, 1, 0, 0, 0));
        // Single-word subtracts: borrow and no borrow.
        send(64'd5, 64'd7, 1, 1, 1, mk(64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 0, 0));
        send(64'd7, 64'd5, 1, 1, 1, mk(64'd2, 0, 1, 1, 0, 0));
        // Signed overflow.
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1, 1, 0, mk(64'h8000_0000_0000_0000, 0, 1, 0, 1, 0));
        // Two-word subtract (2^64 - 1); second beat relies on latched sub.
        send(64'd0, 64'd1, 1, 0, 1, mk(ALL1, 0, 0, 0, 0, 0));
        send(64'd1, 64'd0, 0, 1, 0, mk(64'd0, 1, 1, 1, 0, 0));
        drain();

        // Four-word stream with a 3-cycle output stall after the first result.
        fork
            begin
                send(ALL1,  64'd1, 1, 0, 0, mk(64'd0, 0, 0, 0, 0, 0));
                send(ALL1,  64'd0, 0, 0, 0, mk(64'd0, 1, 0, 0, 0, 0));
                send(64'd0, 64'd0, 0, 0, 0, mk(64'd1, 2, 0, 0, 0, 0));
                send(64'd5, 64'd1, 0, 1, 0, mk(64'd6, 3, 1, 0, 0, 0));
            end
            begin
                for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
                if (!out_valid) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Protocol errors: restart while busy, then a non-first beat in IDLE.
        send(ALL1,   64'd1, 1, 0, 0, mk(64'd0, 0, 0, 0, 0, 0));
        send(64'd1,  64'd1, 1, 1, 0, mk(64'd2, 0, 1, 0, 0, 1));
        send(64'd10, 64'd3, 0, 1, 0, mk(64'd13, 0, 1, 0, 0, 1));
        drain();

        // Reset while a result is held under backpressure.
        @(negedge clk);
        out_ready = 1'b0;
        send(64'd1, 64'd1, 1, 0, 0, mk(64'd2, 0, 0, 0, 0, 0));
        chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        chk_zero_outputs("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(64'd3, 64'd4, 1, 1, 0, mk(64'd7, 0, 1, 0, 0, 0));
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
        $fatal(1);
    end

endmodule
